// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - write/read port bundle between pipeline control and reg_file
interface reg_file_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              RegWrite;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              ready;

  modport master (
    output RegWrite, write_addr, write_data, read_addr_1, read_addr_2,
    input  read_data_1, read_data_2, ready
  );

  modport slave (
    input  RegWrite, write_addr, write_data, read_addr_1, read_addr_2,
    output read_data_1, read_data_2, ready
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - dual-read single-write register file with post-reset clear and write bypass
module reg_file #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              ready_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Entry 0 is never cleared or written; reads of it are forced to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= ADDR_W'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_ptr] <= '0;
          if (clr_ptr == PTR_LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        RUN: begin
          if (bus.RegWrite && bus.write_addr != '0)
            mem[bus.write_addr] <= bus.write_data;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rdy,
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (!rdy || addr == '0)
      return '0;
    else if (we && waddr == addr)
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    bus.read_data_1 = read_port(ready_q, bus.read_addr_1, bus.RegWrite,
                                bus.write_addr, bus.write_data, mem[bus.read_addr_1]);
    bus.read_data_2 = read_port(ready_q, bus.read_addr_2, bus.RegWrite,
                                bus.write_addr, bus.write_data, mem[bus.read_addr_2]);
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  reg_file_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  reg_file #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.RegWrite   = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
    step();
    bus.RegWrite   = 1'b0;
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.RegWrite    = 1'b0;
    bus.write_addr  = '0;
    bus.write_data  = '0;
    bus.read_addr_1 = 6'd5;
    bus.read_addr_2 = 6'd9;

    step();
    check("reset_ready", {31'b0, bus.ready}, 32'h0);
    check("reset_rd1", bus.read_data_1, 32'h0);
    check("reset_rd2", bus.read_data_2, 32'h0);

    // Clear sequence; a write attempt is presented on the 10th edge.
    rst = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      if (i == 10) begin
        bus.RegWrite    = 1'b1;
        bus.write_addr  = 6'd63;
        bus.write_data  = 32'hFFFF_FFFF;
        bus.read_addr_1 = 6'd63;
        #1;
        check("clear_bypass_blocked", bus.read_data_1, 32'h0);
      end
      step();
      bus.RegWrite = 1'b0;
      check($sformatf("clear_ready_edge%0d", i), {31'b0, bus.ready}, (i == 63) ? 32'h1 : 32'h0);
    end

    for (int a = 0; a < 64; a++) begin
      bus.read_addr_1 = 6'(a);
      bus.read_addr_2 = 6'(63 - a);
      #1;
      check($sformatf("cleared_rd1_a%0d", a), bus.read_data_1, 32'h0);
      check($sformatf("cleared_rd2_a%0d", 63 - a), bus.read_data_2, 32'h0);
    end

    wr(6'd5, 32'hDEAD_BEEF);
    bus.read_addr_1 = 6'd5;
    #1;
    check("write5_rd1", bus.read_data_1, 32'hDEAD_BEEF);

    bus.RegWrite    = 1'b1;
    bus.write_addr  = 6'd0;
    bus.write_data  = 32'h1234_5678;
    bus.read_addr_1 = 6'd0;
    bus.read_addr_2 = 6'd0;
    #1;
    check("zero_bypass_rd1", bus.read_data_1, 32'h0);
    step();
    bus.RegWrite = 1'b0;
    #1;
    check("zero_after_rd1", bus.read_data_1, 32'h0);
    check("zero_after_rd2", bus.read_data_2, 32'h0);

    wr(6'd9, 32'h0000_0099);
    bus.RegWrite    = 1'b1;
    bus.write_addr  = 6'd9;
    bus.write_data  = 32'hA5A5_A5A5;
    bus.read_addr_1 = 6'd9;
    bus.read_addr_2 = 6'd9;
    #1;
    check("bypass_rd1", bus.read_data_1, 32'hA5A5_A5A5);
    check("bypass_rd2", bus.read_data_2, 32'hA5A5_A5A5);
    bus.RegWrite = 1'b0;
    #1;
    check("nobypass_rd1", bus.read_data_1, 32'h0000_0099);
    check("nobypass_rd2", bus.read_data_2, 32'h0000_0099);
    step();
    check("old9_kept", bus.read_data_1, 32'h0000_0099);

    for (int i = 1; i < 64; i++) wr(6'(i), 32'(i) * 32'h0101_0101);
    for (int i = 1; i < 64; i++) begin
      bus.read_addr_1 = 6'(i);
      bus.read_addr_2 = 6'(i);
      #1;
      check($sformatf("fill_rd1_a%0d", i), bus.read_data_1, 32'(i) * 32'h0101_0101);
      check($sformatf("fill_rd2_a%0d", i), bus.read_data_2, 32'(i) * 32'h0101_0101);
    end
    bus.read_addr_1 = 6'd17;
    bus.read_addr_2 = 6'd42;
    #1;
    check("split_rd1", bus.read_data_1, 32'h1111_1111);
    check("split_rd2", bus.read_data_2, 32'h2A2A_2A2A);

    // Reset mid-RUN with a simultaneous write that must be dropped.
    wr(6'd7, 32'h0000_0011);
    bus.read_addr_1 = 6'd7;
    bus.read_addr_2 = 6'd8;
    #1;
    check("pre_reset_a7", bus.read_data_1, 32'h0000_0011);
    rst            = 1'b1;
    bus.RegWrite   = 1'b1;
    bus.write_addr = 6'd8;
    bus.write_data = 32'h0000_0022;
    step();
    rst          = 1'b0;
    bus.RegWrite = 1'b0;
    #1;
    check("midrun_ready", {31'b0, bus.ready}, 32'h0);
    check("midrun_rd1", bus.read_data_1, 32'h0);
    check("midrun_rd2", bus.read_data_2, 32'h0);
    for (int i = 1; i < 63; i++) step();
    check("reclear_ready62", {31'b0, bus.ready}, 32'h0);
    step();
    check("reclear_ready63", {31'b0, bus.ready}, 32'h1);
    check("reclear_a7", bus.read_data_1, 32'h0);
    check("reclear_a8", bus.read_data_2, 32'h0);

    // Reset mid-clear restarts the full count.
    for (int i = 0; i < 5; i++) begin
      rst = (i == 0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i < 63; i++) step();
    check("midclear_ready62", {31'b0, bus.ready}, 32'h0);
    step();
    check("midclear_ready63", {31'b0, bus.ready}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
